// File: rtl/aeolus_pkg.sv
// Shared definitions for the Aeolus self-test: sequencer states, width helpers
// and the default vector ROM used by the board top.
package aeolus_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StResetCpu,
    StRun,
    StCheck,
    StDone
  } seq_state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned DEFAULT_NUM_VECTORS = 4;

  // Returns {switches[7:0], expected[3:0]} for the board-level default table.
  function automatic logic [11:0] default_vector(input int unsigned idx);
    logic [11:0] v;
    case (idx)
      0:       v = {8'h3E, 4'h1};
      1:       v = {8'h12, 4'h3};
      2:       v = {8'hFF, 4'hE};
      default: v = {8'h00, 4'h0};
    endcase
    return v;
  endfunction

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter with zero flag; times the CPU reset and run phases.
module phase_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/cpu_selftest_sequencer.sv
// Walks an external vector table, resetting and running the CPU once per vector
// and checking its output nibble; results are reported on-chip.
module cpu_selftest_sequencer
  import aeolus_pkg::*;
#(
  parameter int unsigned SW_WIDTH     = 8,
  parameter int unsigned OUT_WIDTH    = 4,
  parameter int unsigned NUM_VECTORS  = 4,
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned RUN_CYCLES   = 100,
  parameter int unsigned STOP_ON_FAIL = 1,
  localparam int unsigned IDX_W       = idx_w(NUM_VECTORS),
  localparam int unsigned CNT_W       = cnt_w(NUM_VECTORS)
) (
  input  logic                 boardCLK,
  input  logic                 reset,
  input  logic                 start,
  output logic [IDX_W-1:0]     vec_index,
  input  logic [SW_WIDTH-1:0]  vec_switches,
  input  logic [OUT_WIDTH-1:0] vec_expected,
  output logic                 cpu_reset,
  output logic [SW_WIDTH-1:0]  cpu_switches,
  input  logic [OUT_WIDTH-1:0] cpu_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [IDX_W-1:0]     fail_index,
  output logic [OUT_WIDTH-1:0] fail_got,
  output logic [CNT_W-1:0]     fail_count
);

  localparam int unsigned CTR_MAX = (RESET_CYCLES > RUN_CYCLES) ? RESET_CYCLES : RUN_CYCLES;
  localparam int unsigned CTR_W   = $clog2(CTR_MAX + 1);
  // The counter reaches zero in the last cycle of a phase, hence the -1.
  localparam logic [CTR_W-1:0] RESET_LOAD = CTR_W'(RESET_CYCLES - 1);
  localparam logic [CTR_W-1:0] RUN_LOAD   = CTR_W'(RUN_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] MAX_FAILS  = CNT_W'(NUM_VECTORS);

  seq_state_e           state_q, state_d;
  logic [IDX_W-1:0]     vec_index_q, vec_index_d;
  logic [SW_WIDTH-1:0]  cpu_switches_q, cpu_switches_d;
  logic [IDX_W-1:0]     fail_index_q, fail_index_d;
  logic [OUT_WIDTH-1:0] fail_got_q, fail_got_d;
  logic [CNT_W-1:0]     fail_count_q, fail_count_d;

  logic             ctr_load;
  logic [CTR_W-1:0] ctr_value;
  logic             ctr_zero;
  logic             mismatch;

  phase_counter #(
    .WIDTH(CTR_W)
  ) u_phase_counter (
    .clk       (boardCLK),
    .reset     (reset),
    .load      (ctr_load),
    .load_value(ctr_value),
    .zero      (ctr_zero)
  );

  always_comb begin
    state_d        = state_q;
    vec_index_d    = vec_index_q;
    cpu_switches_d = cpu_switches_q;
    fail_index_d   = fail_index_q;
    fail_got_d     = fail_got_q;
    fail_count_d   = fail_count_q;
    ctr_load       = 1'b0;
    ctr_value      = RESET_LOAD;
    mismatch       = 1'b0;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d      = StResetCpu;
          vec_index_d  = '0;
          fail_index_d = '0;
          fail_got_d   = '0;
          fail_count_d = '0;
          ctr_load     = 1'b1;
          ctr_value    = RESET_LOAD;
        end
      end
      StResetCpu: begin
        cpu_switches_d = vec_switches;
        if (ctr_zero) begin
          state_d   = StRun;
          ctr_load  = 1'b1;
          ctr_value = RUN_LOAD;
        end
      end
      StRun: begin
        if (ctr_zero) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        mismatch = (cpu_out != vec_expected);
        if (mismatch) begin
          if (fail_count_q != MAX_FAILS) begin
            fail_count_d = fail_count_q + 1'b1;
          end
          if (fail_count_q == '0) begin
            fail_index_d = vec_index_q;
            fail_got_d   = cpu_out;
          end
        end
        if (mismatch && (STOP_ON_FAIL != 0)) begin
          state_d = StDone;
        end else if (vec_index_q == LAST_IDX) begin
          state_d = StDone;
        end else begin
          vec_index_d = vec_index_q + 1'b1;
          state_d     = StResetCpu;
          ctr_load    = 1'b1;
          ctr_value   = RESET_LOAD;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge boardCLK) begin
    if (reset) begin
      state_q        <= StIdle;
      vec_index_q    <= '0;
      cpu_switches_q <= '0;
      fail_index_q   <= '0;
      fail_got_q     <= '0;
      fail_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      vec_index_q    <= vec_index_d;
      cpu_switches_q <= cpu_switches_d;
      fail_index_q   <= fail_index_d;
      fail_got_q     <= fail_got_d;
      fail_count_q   <= fail_count_d;
    end
  end

  assign cpu_reset    = !((state_q == StRun) || (state_q == StCheck));
  assign busy         = (state_q == StResetCpu) || (state_q == StRun) || (state_q == StCheck);
  assign done         = (state_q == StDone);
  assign pass         = done && (fail_count_q == '0);
  assign vec_index    = vec_index_q;
  assign cpu_switches = cpu_switches_q;
  assign fail_index   = fail_index_q;
  assign fail_got     = fail_got_q;
  assign fail_count   = fail_count_q;

endmodule

// File: tb/tb_cpu_selftest_sequencer.sv
// Bench: two sequencers (stop-on-fail and run-all) driving stub CPUs from a
// shared vector table; table cases, corner sequences and random tables.
module tb_cpu_selftest_sequencer;

  localparam int unsigned NV  = 3;
  localparam int unsigned RC  = 2;
  localparam int unsigned RN  = 5;
  localparam int          PER = RC + RN + 1;

  typedef struct {
    logic [2:0][7:0] sw;
    logic [2:0][3:0] ex;
    int              cyc_s;
    int              cyc_c;
    int              cnt_s;
    int              cnt_c;
    bit              pass;
    int              fidx;
    logic [3:0]      fgot;
  } vec_t;

  int checks = 0;
  int failures = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  vec_t cur;

  always #5 clk = ~clk;

  // stop-on-fail instance (s_) and run-all instance (c_)
  logic [1:0] s_idx, c_idx, s_fidx, c_fidx, s_fcnt, c_fcnt;
  logic [7:0] s_vsw, c_vsw, s_csw, c_csw;
  logic [3:0] s_vex, c_vex, s_out, c_out, s_fgot, c_fgot;
  logic       s_crst, c_crst, s_busy, c_busy, s_done, c_done, s_pass, c_pass;

  always_comb begin
    s_vsw = '0;
    s_vex = '0;
    c_vsw = '0;
    c_vex = '0;
    if (s_idx < 2'd3) begin
      s_vsw = cur.sw[s_idx];
      s_vex = cur.ex[s_idx];
    end
    if (c_idx < 2'd3) begin
      c_vsw = cur.sw[c_idx];
      c_vex = cur.ex[c_idx];
    end
  end

  // Stub CPU: registered nibble sum of the switches, cleared while in reset.
  always_ff @(posedge clk) begin
    s_out <= s_crst ? 4'h0 : 4'(s_csw[7:4] + s_csw[3:0]);
    c_out <= c_crst ? 4'h0 : 4'(c_csw[7:4] + c_csw[3:0]);
  end

  cpu_selftest_sequencer #(
    .SW_WIDTH(8), .OUT_WIDTH(4), .NUM_VECTORS(NV), .RESET_CYCLES(RC),
    .RUN_CYCLES(RN), .STOP_ON_FAIL(1)
  ) dut_s (
    .boardCLK(clk), .reset(reset), .start(start), .vec_index(s_idx),
    .vec_switches(s_vsw), .vec_expected(s_vex), .cpu_reset(s_crst),
    .cpu_switches(s_csw), .cpu_out(s_out), .busy(s_busy), .done(s_done),
    .pass(s_pass), .fail_index(s_fidx), .fail_got(s_fgot), .fail_count(s_fcnt)
  );

  cpu_selftest_sequencer #(
    .SW_WIDTH(8), .OUT_WIDTH(4), .NUM_VECTORS(NV), .RESET_CYCLES(RC),
    .RUN_CYCLES(RN), .STOP_ON_FAIL(0)
  ) dut_c (
    .boardCLK(clk), .reset(reset), .start(start), .vec_index(c_idx),
    .vec_switches(c_vsw), .vec_expected(c_vex), .cpu_reset(c_crst),
    .cpu_switches(c_csw), .cpu_out(c_out), .busy(c_busy), .done(c_done),
    .pass(c_pass), .fail_index(c_fidx), .fail_got(c_fgot), .fail_count(c_fcnt)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0][7:0] sw, input logic [2:0][3:0] ex,
                              input int cyc_s, input int cnt_s, input int cnt_c,
                              input bit pass, input int fidx, input logic [3:0] fgot);
    vec_t r;
    r.sw = sw; r.ex = ex; r.cyc_s = cyc_s; r.cyc_c = NV * PER;
    r.cnt_s = cnt_s; r.cnt_c = cnt_c; r.pass = pass; r.fidx = fidx; r.fgot = fgot;
    return r;
  endfunction

  // Reference: evaluate every vector, then derive what each policy reports.
  function automatic vec_t model(input logic [2:0][7:0] sw, input logic [2:0][3:0] ex);
    vec_t r;
    int first = -1;
    logic [3:0] got;
    r.sw = sw; r.ex = ex; r.cnt_c = 0; r.fidx = 0; r.fgot = '0;
    for (int i = 0; i < NV; i++) begin
      got = 4'(sw[i][7:4] + sw[i][3:0]);
      if (got != ex[i]) begin
        r.cnt_c++;
        if (first < 0) begin
          first = i; r.fidx = i; r.fgot = got;
        end
      end
    end
    r.pass  = (r.cnt_c == 0);
    r.cyc_c = NV * PER;
    r.cyc_s = (first < 0) ? NV * PER : (first + 1) * PER;
    r.cnt_s = (first < 0) ? 0 : 1;
    return r;
  endfunction

  // Entered at posedge+#1; pulses start and follows both DUTs to DONE.
  task automatic run_seq(input vec_t v, input bit noise, input string tag);
    int n = 0, cyc_s = -1, cyc_c = -1, low_s = 0, low_c = 0;
    cur = v;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, " s_busy_after_start"}, s_busy, 1);
    chk({tag, " results_cleared"}, {s_fcnt, c_fcnt, s_fidx, c_fidx, s_fgot, c_fgot, s_done}, 0);
    while (n < 4 * NV * PER && (cyc_s < 0 || cyc_c < 0)) begin
      start = noise && s_busy && c_busy && (n % 3 == 1);
      @(posedge clk); #1;
      start = 1'b0;
      n++;
      if (!s_crst) low_s++;
      if (!c_crst) low_c++;
      if (s_done && cyc_s < 0) cyc_s = n;
      if (c_done && cyc_c < 0) cyc_c = n;
    end
    chk({tag, " s_done_cycle"}, cyc_s, v.cyc_s);
    chk({tag, " c_done_cycle"}, cyc_c, v.cyc_c);
    chk({tag, " s_fail_count"}, s_fcnt, v.cnt_s);
    chk({tag, " c_fail_count"}, c_fcnt, v.cnt_c);
    chk({tag, " pass"}, {s_pass, c_pass}, {v.pass, v.pass});
    chk({tag, " fail_index"}, {s_fidx, c_fidx}, {2'(v.fidx), 2'(v.fidx)});
    chk({tag, " fail_got"}, {s_fgot, c_fgot}, {v.fgot, v.fgot});
    chk({tag, " s_release_cycles"}, low_s, (v.cyc_s / PER) * (RN + 1));
    chk({tag, " c_release_cycles"}, low_c, NV * (RN + 1));
    chk({tag, " done_state"}, {s_crst, c_crst, s_busy, c_busy}, 4'b1100);
  endtask

  vec_t tbl[5];

  initial begin
    logic [2:0][7:0] rsw;
    logic [2:0][3:0] rex;
    // sw/ex packed as {v2, v1, v0}
    tbl[0] = mk({8'hFF, 8'h12, 8'h3E}, {4'hE, 4'h3, 4'h1}, 24, 0, 0, 1, 0, 4'h0);
    tbl[1] = mk({8'hFF, 8'h12, 8'h3E}, {4'hE, 4'h4, 4'h1}, 16, 1, 1, 0, 1, 4'h3);
    tbl[2] = mk({8'hFF, 8'h12, 8'h3E}, {4'h0, 4'h4, 4'h1}, 16, 1, 2, 0, 1, 4'h3);
    tbl[3] = mk({8'hFF, 8'h12, 8'h3E}, {4'hE, 4'h3, 4'h0}, 8, 1, 1, 0, 0, 4'h1);
    tbl[4] = mk({8'hFF, 8'h12, 8'h3E}, {4'h0, 4'h0, 4'h0}, 8, 1, 3, 0, 0, 4'h1);
    cur = tbl[0];

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {s_crst, c_crst, s_busy, c_busy, s_done, c_done, s_pass, c_pass},
        8'b1100_0000);
    chk("reset_data", {s_idx, c_idx, s_csw, c_csw, s_fidx, s_fgot, s_fcnt, c_fcnt}, 0);

    // reset and start on the same edge: reset wins
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("reset_beats_start", {s_busy, c_busy, s_crst}, 3'b001);
    reset = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) run_seq(tbl[i], 1'b0, $sformatf("tbl%0d", i));

    // start pulses while busy, then restart from DONE with identical trace
    run_seq(tbl[0], 1'b1, "busy_noise");
    run_seq(tbl[2], 1'b0, "pre_restart");
    run_seq(tbl[0], 1'b0, "restart");

    // reset during RUN of vector 1
    cur = tbl[1];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (PER + RC + 1) @(posedge clk);
    #1;
    chk("mid_run_state", {s_crst, s_busy, s_idx}, {1'b0, 1'b1, 2'd1});
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_reset_ctrl", {s_crst, c_crst, s_busy, c_busy, s_done, c_done}, 6'b110000);
    chk("mid_reset_data", {s_idx, c_idx, s_csw, c_csw, s_fcnt, c_fcnt}, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    run_seq(tbl[0], 1'b0, "after_reset");

    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < NV; i++) begin
        rsw[i] = 8'($urandom);
        rex[i] = ($urandom_range(0, 1) == 1) ? 4'(rsw[i][7:4] + rsw[i][3:0]) : 4'($urandom);
      end
      run_seq(model(rsw, rex), 1'($urandom_range(0, 1)), $sformatf("rand%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
